// File: rtl/uart_rx_ctrl_cfg.sv
// Runtime-configurable UART receive controller: frame FSM, edge/bit counters,
// 3-sample majority sampler, LSB-first deserializer and parity/start/stop checks.
module uart_rx_ctrl_cfg #(
  parameter int MAX_DATA_W = 9,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic [3:0]            DATA_LEN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [MAX_DATA_W-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  STRT_GLITCH,
  output logic                  BUSY
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                  state, state_nx;
  logic [PRESCALE_W-1:0]   e_cnt, e_nx, presc_q, half;
  logic [3:0]              b_cnt, b_nx, len_q;
  logic                    par_en_q, par_typ_q, stop2_q;
  logic                    s0, s1, maj_now, bit_end, samp_pt;
  logic [MAX_DATA_W-1:0]   shift_q, shift_nx;
  logic                    perr_q, perr_nx, serr_q, serr_nx;
  logic                    dv_nx, pe_nx, se_nx, sg_nx, latch_cfg;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // The third sample is taken live at E = H+1, so each bit decision is
  // registered by the edge that opens E = H+2.
  assign half    = presc_q >> 1;
  assign bit_end = (e_cnt == presc_q - PRESCALE_W'(1));
  assign samp_pt = (e_cnt == half + PRESCALE_W'(1));
  assign maj_now = maj3(s0, s1, RX_IN);

  always_comb begin
    state_nx  = state;
    e_nx      = bit_end ? '0 : e_cnt + PRESCALE_W'(1);
    b_nx      = b_cnt;
    shift_nx  = shift_q;
    perr_nx   = perr_q;
    serr_nx   = serr_q;
    dv_nx     = 1'b0;
    pe_nx     = 1'b0;
    se_nx     = 1'b0;
    sg_nx     = 1'b0;
    latch_cfg = 1'b0;
    case (state)
      IDLE: begin
        e_nx = '0;
        if (!RX_IN) begin
          state_nx  = START;
          e_nx      = PRESCALE_W'(1);
          latch_cfg = 1'b1;
        end
      end
      START: begin
        if (samp_pt && maj_now) begin
          sg_nx    = 1'b1;
          state_nx = IDLE;
          e_nx     = '0;
        end else if (bit_end) begin
          state_nx = DATA;
          b_nx     = '0;
        end
      end
      DATA: begin
        if (samp_pt && (b_cnt < 4'(MAX_DATA_W))) shift_nx[b_cnt] = maj_now;
        if (bit_end) begin
          if (b_cnt == len_q - 4'd1) begin
            state_nx = par_en_q ? PARITY : STOP;
            b_nx     = '0;
          end else begin
            b_nx = b_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (samp_pt) perr_nx = (maj_now != ((^shift_q) ^ par_typ_q));
        if (bit_end) begin
          state_nx = STOP;
          b_nx     = '0;
        end
      end
      STOP: begin
        if (samp_pt && !maj_now) serr_nx = 1'b1;
        if (bit_end) begin
          if (b_cnt == {3'b000, stop2_q}) begin
            state_nx = DONE;
            e_nx     = '0;
            dv_nx    = !perr_nx && !serr_nx;
            pe_nx    = perr_nx;
            se_nx    = serr_nx;
          end else begin
            b_nx = b_cnt + 4'd1;
          end
        end
      end
      DONE: begin
        e_nx     = '0;
        state_nx = IDLE;
        if (!RX_IN) begin
          state_nx  = START;
          e_nx      = PRESCALE_W'(1);
          latch_cfg = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        e_nx     = '0;
      end
    endcase
    if (latch_cfg) begin
      shift_nx = '0;
      perr_nx  = 1'b0;
      serr_nx  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      e_cnt       <= '0;
      b_cnt       <= '0;
      presc_q     <= '0;
      len_q       <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      stop2_q     <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
      P_DATA      <= '0;
      DATA_VALID  <= 1'b0;
      PAR_ERR     <= 1'b0;
      STP_ERR     <= 1'b0;
      STRT_GLITCH <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      state       <= state_nx;
      e_cnt       <= e_nx;
      b_cnt       <= b_nx;
      perr_q      <= perr_nx;
      serr_q      <= serr_nx;
      DATA_VALID  <= dv_nx;
      PAR_ERR     <= pe_nx;
      STP_ERR     <= se_nx;
      STRT_GLITCH <= sg_nx;
      BUSY        <= (state_nx != IDLE);
      if (dv_nx) P_DATA <= shift_q;
      if (latch_cfg) begin
        presc_q   <= PRESCALE;
        len_q     <= DATA_LEN;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
      end
    end
  end

  // Datapath registers: meaningful only while a frame is in flight.
  always_ff @(posedge CLK) begin
    shift_q <= shift_nx;
    if (e_cnt == half - PRESCALE_W'(1)) s0 <= RX_IN;
    if (e_cnt == half) s1 <= RX_IN;
  end

endmodule

// File: tb/tb_uart_rx_ctrl_cfg.sv
// Bench for uart_rx_ctrl_cfg: frames are built as bit lists from the config and
// data, and expected pulses/words come from frame arithmetic, not from the RTL.
module tb_uart_rx_ctrl_cfg;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic [3:0] DATA_LEN = 4'd8;
  logic       PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
  logic [8:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH, BUSY;

  uart_rx_ctrl_cfg #(.MAX_DATA_W(9), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE), .DATA_LEN(DATA_LEN),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
    .STRT_GLITCH(STRT_GLITCH), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct { int cyc; logic dv, pe, se, sg; logic [8:0] pd; } ev_t;
  typedef struct { int cyc; logic dv, pe, se; logic [8:0] pd; } exp_t;

  int   cyc = 0;
  int   passed = 0, total = 0;
  ev_t  evq[$];
  logic busy_hist[int];
  logic [8:0] last_word = 9'h0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    busy_hist[cyc] = BUSY;
    if (DATA_VALID || PAR_ERR || STP_ERR || STRT_GLITCH)
      evq.push_back('{cyc, DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH, P_DATA});
  end

  function automatic ev_t get_ev(input int c);
    ev_t r;
    r = '{-1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0};
    foreach (evq[i]) if (evq[i].cyc == c) r = evq[i];
    return r;
  endfunction

  function automatic logic [8:0] mask_of(input int len);
    logic [8:0] m;
    m = 9'((1 << len) - 1);
    return m;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      RX_IN = 1'b1;
    end
  endtask

  // Drive one frame; config ports are scrambled right after the start-detect cycle.
  task automatic send_frame(input int p, input int len, input logic [8:0] data,
                            input logic pen, input logic ptyp, input logic st2,
                            input logic bad_par, input logic bad_stop,
                            input int flip_fb, output int t0);
    logic bq[$];
    logic par;
    par = ptyp;
    bq.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      bq.push_back(data[i]);
      par ^= data[i];
    end
    if (pen) bq.push_back(par ^ bad_par);
    bq.push_back(!bad_stop);
    if (st2) bq.push_back(1'b1);
    t0 = 0;
    for (int fb = 0; fb < bq.size(); fb++) begin
      for (int e = 0; e < p; e++) begin
        @(posedge CLK); #1;
        if (fb == 0 && e == 0) begin
          PRESCALE = 6'(p); DATA_LEN = 4'(len);
          PAR_EN = pen; PAR_TYP = ptyp; STOP2 = st2;
          t0 = cyc;
        end else if (fb == 0 && e == 1) begin
          PRESCALE = 6'(2 * $urandom_range(3, 31)); DATA_LEN = 4'($urandom_range(5, 9));
          PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
        end
        RX_IN = bq[fb] ^ ((fb == flip_fb) && (e == p / 2));
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({P_DATA, DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH, BUSY} !== 14'h0)
      $display("FAIL reset_hold: outputs=%h want 0", {P_DATA, DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH, BUSY});
    else passed++;
    @(posedge CLK); #1;
    RST = 1'b1;
    evq.delete();
    idle(4);
    @(negedge CLK);
    total++;
    if ({P_DATA, DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH, BUSY} !== 14'h0 || evq.size() != 0)
      $display("FAIL reset_release: outputs=%h events=%0d want 0/0",
               {P_DATA, DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH, BUSY}, evq.size());
    else passed++;
    last_word = 9'h0;
  endtask

  task automatic test_8n1();
    int t0;
    ev_t e;
    evq.delete();
    send_frame(8, 8, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, t0);
    idle(4);
    e = get_ev(t0 + 80);
    total++;
    if ({e.dv, e.pe, e.se, e.sg} !== 4'b1000 || e.pd !== 9'h0A5)
      $display("FAIL 8n1_a5: dv/pe/se/sg=%b pd=%h want 1000 0a5", {e.dv, e.pe, e.se, e.sg}, e.pd);
    else passed++;
    total++;
    if (evq.size() != 1) $display("FAIL 8n1_pulse_count: got %0d want 1", evq.size());
    else passed++;
    total++;
    if (busy_hist[t0 + 1] !== 1'b1 || busy_hist[t0 + 81] !== 1'b0)
      $display("FAIL 8n1_busy: t0+1=%b t0+81=%b want 1 0", busy_hist[t0 + 1], busy_hist[t0 + 81]);
    else passed++;
    last_word = 9'h0A5;
  endtask

  task automatic test_parity_err();
    int t0;
    ev_t e;
    evq.delete();
    send_frame(16, 7, 9'h035, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, t0);
    idle(4);
    e = get_ev(t0 + 176);
    total++;
    if ({e.dv, e.pe, e.se, e.sg} !== 4'b0100 || evq.size() != 1)
      $display("FAIL parity_err: dv/pe/se/sg=%b events=%0d want 0100 1", {e.dv, e.pe, e.se, e.sg}, evq.size());
    else passed++;
    total++;
    if (P_DATA !== last_word) $display("FAIL parity_hold: P_DATA=%h want %h", P_DATA, last_word);
    else passed++;
  endtask

  task automatic test_stop_err();
    int t0, t1;
    ev_t e;
    evq.delete();
    send_frame(8, 8, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, t0);
    idle(3);
    send_frame(8, 8, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, t1);
    idle(4);
    e = get_ev(t0 + 80);
    total++;
    if ({e.dv, e.pe, e.se, e.sg} !== 4'b0010 || e.pd !== last_word)
      $display("FAIL stop_err: dv/pe/se/sg=%b pd=%h want 0010 %h", {e.dv, e.pe, e.se, e.sg}, e.pd, last_word);
    else passed++;
    e = get_ev(t1 + 80);
    total++;
    if ({e.dv, e.pe, e.se, e.sg} !== 4'b1000 || e.pd !== 9'h03C || evq.size() != 2)
      $display("FAIL stop_recover: dv/pe/se/sg=%b pd=%h events=%0d want 1000 03c 2",
               {e.dv, e.pe, e.se, e.sg}, e.pd, evq.size());
    else passed++;
    last_word = 9'h03C;
  endtask

  task automatic test_glitch();
    int t0;
    ev_t e;
    evq.delete();
    @(posedge CLK); #1;
    PRESCALE = 6'd8; DATA_LEN = 4'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
    RX_IN = 1'b0;
    t0 = cyc;
    @(posedge CLK); #1;
    RX_IN = 1'b0;
    idle(12);
    e = get_ev(t0 + 6);
    total++;
    if ({e.dv, e.pe, e.se, e.sg} !== 4'b0001 || evq.size() != 1)
      $display("FAIL glitch: dv/pe/se/sg=%b events=%0d want 0001 1", {e.dv, e.pe, e.se, e.sg}, evq.size());
    else passed++;
    total++;
    if (busy_hist[t0 + 7] !== 1'b0 || busy_hist[t0 + 1] !== 1'b1)
      $display("FAIL glitch_busy: t0+1=%b t0+7=%b want 1 0", busy_hist[t0 + 1], busy_hist[t0 + 7]);
    else passed++;
    total++;
    if (P_DATA !== last_word) $display("FAIL glitch_hold: P_DATA=%h want %h", P_DATA, last_word);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    logic [8:0] w2;
    ev_t e;
    evq.delete();
    w2 = 9'($urandom);
    send_frame(8, 9, 9'h1B7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, t0);
    send_frame(8, 9, w2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, t1);
    idle(4);
    e = get_ev(t0 + 96);
    total++;
    if ({e.dv, e.pe, e.se, e.sg} !== 4'b1000 || e.pd !== 9'h1B7)
      $display("FAIL majority_1b7: dv/pe/se/sg=%b pd=%h want 1000 1b7", {e.dv, e.pe, e.se, e.sg}, e.pd);
    else passed++;
    e = get_ev(t1 + 96);
    total++;
    if ({e.dv, e.pe, e.se, e.sg} !== 4'b1000 || e.pd !== w2 || evq.size() != 2)
      $display("FAIL b2b_second: dv/pe/se/sg=%b pd=%h events=%0d want 1000 %h 2",
               {e.dv, e.pe, e.se, e.sg}, e.pd, evq.size(), w2);
    else passed++;
    last_word = w2;
  endtask

  task automatic test_reset_mid();
    int t0;
    ev_t e;
    evq.delete();
    @(posedge CLK); #1;
    PRESCALE = 6'd8; DATA_LEN = 4'd8; PAR_EN = 1'b0; STOP2 = 1'b0;
    RX_IN = 1'b0;
    repeat (7) begin @(posedge CLK); #1; end
    repeat (20) begin @(posedge CLK); #1; RX_IN = 1'b1; end
    RST = 1'b0;
    #1;
    total++;
    if ({P_DATA, DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH, BUSY} !== 14'h0)
      $display("FAIL reset_mid: outputs=%h want 0", {P_DATA, DATA_VALID, PAR_ERR, STP_ERR, STRT_GLITCH, BUSY});
    else passed++;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    last_word = 9'h0;
    idle(3);
    @(negedge CLK);
    total++;
    if (BUSY !== 1'b0 || evq.size() != 0)
      $display("FAIL reset_mid_idle: busy=%b events=%0d want 0 0", BUSY, evq.size());
    else passed++;
    send_frame(8, 8, 9'h096, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, t0);
    idle(4);
    e = get_ev(t0 + 80);
    total++;
    if ({e.dv, e.pe, e.se, e.sg} !== 4'b1000 || e.pd !== 9'h096 || evq.size() != 1)
      $display("FAIL reset_mid_next: dv/pe/se/sg=%b pd=%h events=%0d want 1000 096 1",
               {e.dv, e.pe, e.se, e.sg}, e.pd, evq.size());
    else passed++;
    last_word = 9'h096;
  endtask

  task automatic test_random();
    exp_t xq[$];
    ev_t  e;
    int   p, len, t0, flip;
    logic pen, ptyp, st2, bp, bs, dv;
    logic [8:0] data;
    evq.delete();
    for (int n = 0; n < 30; n++) begin
      p    = 2 * $urandom_range(3, 8);
      len  = $urandom_range(5, 9);
      data = 9'($urandom) & mask_of(len);
      pen  = 1'($urandom); ptyp = 1'($urandom); st2 = 1'($urandom);
      bp   = pen && ($urandom_range(0, 4) == 0);
      bs   = ($urandom_range(0, 5) == 0);
      flip = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : -1;
      send_frame(p, len, data, pen, ptyp, st2, bp, bs, flip, t0);
      dv = !bp && !bs;
      if (dv) last_word = data;
      xq.push_back('{t0 + p * (2 + len + int'(pen) + int'(st2)), dv, bp, bs, last_word});
      idle($urandom_range(0, 2));
    end
    idle(4);
    total++;
    if (evq.size() != xq.size()) $display("FAIL random_count: got %0d want %0d", evq.size(), xq.size());
    else passed++;
    foreach (xq[i]) begin
      e = get_ev(xq[i].cyc);
      total++;
      if ({e.dv, e.pe, e.se, e.sg} !== {xq[i].dv, xq[i].pe, xq[i].se, 1'b0} || e.pd !== xq[i].pd)
        $display("FAIL random_frame%0d: cyc=%0d dv/pe/se/sg=%b pd=%h want %b0 %h", i, xq[i].cyc,
                 {e.dv, e.pe, e.se, e.sg}, e.pd, {xq[i].dv, xq[i].pe, xq[i].se}, xq[i].pd);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
